mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one fixed-latency, single-ported unified memory between the IF-stage
//  instruction fetch port and the MEM-stage load/store port of the pipelined CPU.
//  Grants one transaction at a time, data port first, and holds stall_o so the
//  pipeline freezes PC, IF_ID and later pipeline registers until the request completes.
// PARAMETERS
//  ADDR_W   32  address width, both ports and memory side
//  DATA_W   32  data width
//  MEM_LAT  3   cycles from the issue cycle to mem_rdata_i valid; must be >=1
//  CNT_W    16  perf counter width; used only with MEM_ARB_PERF_EN
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, synchronous, active-low
//  if_req_i     in   1       fetch request; level, held until if_ack_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_data_o    out  DATA_W  fetched word; valid when if_ack_o=1
//  if_ack_o     out  1       one-cycle fetch completion pulse
//  dm_req_i     in   1       data request; level, held until dm_ack_o
//  dm_we_i      in   1       1=store, 0=load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data; valid when dm_ack_o=1
//  dm_ack_o     out  1       one-cycle data completion pulse
//  mem_en_o     out  1       memory issue strobe; one cycle per transaction
//  mem_we_o     out  1       write enable; qualified by mem_en_o
//  mem_addr_o   out  ADDR_W  address; held for the whole transaction
//  mem_wdata_o  out  DATA_W  write data; held for the whole transaction
//  mem_rdata_i  in   DATA_W  read data; valid exactly MEM_LAT cycles after issue
//  stall_o      out  1       pipeline stall; combinational
// BEHAVIOUR
//  - Reset (rst_i=0 at an edge): state=IDLE; latency counter=0. All registered
//    outputs go to 0: mem_*_o, acks, if_data_o, dm_rdata_o.
//  - FSM states: IDLE, BUSY_IF, BUSY_DM.
//    - In IDLE, a request from a port is not eligible in a cycle where that port's
//      ack_o=1, because its req is still high.
//    - IDLE -> BUSY_DM if dm_req_i is eligible. Otherwise IDLE -> BUSY_IF if
//      if_req_i is eligible. The data port always wins.
//  - Grant edge: latch addr, we and wdata into mem_addr_o, mem_we_o (0 for fetch) and
//    mem_wdata_o. Set mem_en_o=1 for the next cycle only (issue cycle I). Load the
//    counter with MEM_LAT.
//  - Inputs that change while BUSY are ignored. The latched copy is used.
//  - The counter decrements every BUSY cycle after I. At cycle I+MEM_LAT, register
//    mem_rdata_i into if_data_o or dm_rdata_o, then return to IDLE.
//  - ack_o=1 only in cycle I+MEM_LAT+1. Latency from an eligible req in IDLE to ack
//    is MEM_LAT+2 cycles.
//  - Stores use the same timing. dm_rdata_o is left unchanged on a store.
//  - mem_we_o returns to 0 in the cycle after issue. mem_addr_o and mem_wdata_o hold
//    their values until the next grant.
//  - The other port may be granted in the ack cycle. Example: a fetch waiting behind a
//    data access issues at dm_ack+1.
//  - If a requester drops req mid-transaction, the transaction still completes and
//    the ack still pulses.
//  - stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
//  - Reset mid-transaction aborts it: no ack is issued, and the FSM is in IDLE
//    at the next edge.
// CONFIGURATION
//  - MEM_ARB_PERF_EN defined: adds outputs perf_if_wait_o[CNT_W-1:0] and
//    perf_dm_wait_o[CNT_W-1:0].
//    - Each counts cycles with req_i=1 and ack_o=0 on its port.
//    - Each saturates at all-ones and clears on reset.
//  - MEM_ARB_PERF_EN undefined: these ports and counters do not exist.
//    Other behaviour is identical.
// TESTING
//  1. rst_i=0 for 2 cycles with random inputs -> all outputs 0; no mem_en_o pulse.
//  2. MEM_LAT=3; if_req at t with addr 0x40; mem returns 0x8C020000 at t+4 ->
//     mem_en_o=1 at t+1 with addr 0x40 and we=0; if_ack_o=1 at t+5 with
//     if_data_o=0x8C020000; stall_o=1 for t..t+4.
//  3. if_req(0x44) and dm load(0x100) both at t -> dm issue at t+1, dm_ack at t+5,
//     if issue at t+6, if_ack at t+10; stall_o high t..t+9.
//  4. dm store addr 0x200 wdata 0xDEADBEEF -> mem_en_o=mem_we_o=1 at t+1 with
//     mem_wdata_o=0xDEADBEEF; dm_ack_o at t+5; dm_rdata_o unchanged.
//  5. rst_i=0 at I+1 of a fetch -> no if_ack_o; IDLE next cycle; a new fetch after
//     reset completes in MEM_LAT+2 cycles.
//  6. MEM_ARB_PERF_EN, CNT_W=4 -> test 3 gives perf_if_wait_o=10 and perf_dm_wait_o=5.
//     A 20-cycle wait saturates at 15.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch port and the data port.
// Optional MEM_ARB_PERF_EN adds saturating per-port wait-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_if_wait_o,
    output logic [CNT_W-1:0]  perf_dm_wait_o
`endif
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("mem_port_arbiter: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LAT_W-1:0]   lat_cnt;
    logic               is_store;
    logic               if_elig;
    logic               dm_elig;
    logic               grant_if;
    logic               grant_dm;
    logic               finish_if;
    logic               finish_dm;

    // A requester whose ack is high this cycle is still holding req for the finished access.
    assign if_elig = if_req_i & ~if_ack_o;
    assign dm_elig = dm_req_i & ~dm_ack_o;
    assign stall_o = if_elig | dm_elig;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        finish_if  = 1'b0;
        finish_dm  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_elig) begin
                    state_next = BUSY_DM;
                    grant_dm   = 1'b1;
                end else if (if_elig) begin
                    state_next = BUSY_IF;
                    grant_if   = 1'b1;
                end
            end
            BUSY_IF: begin
                if (lat_cnt == '0) begin
                    state_next = IDLE;
                    finish_if  = 1'b1;
                end
            end
            BUSY_DM: begin
                if (lat_cnt == '0) begin
                    state_next = IDLE;
                    finish_dm  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // lat_cnt reaches zero in the cycle mem_rdata_i is valid (issue + MEM_LAT).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lat_cnt     <= '0;
            is_store    <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
        end else begin
            mem_en_o <= grant_if | grant_dm;
            mem_we_o <= grant_dm & dm_we_i;
            if_ack_o <= finish_if;
            dm_ack_o <= finish_dm;
            if (grant_dm) begin
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                is_store    <= dm_we_i;
                lat_cnt     <= LAT_W'(MEM_LAT);
            end else if (grant_if) begin
                mem_addr_o  <= if_addr_i;
                is_store    <= 1'b0;
                lat_cnt     <= LAT_W'(MEM_LAT);
            end else if (state != IDLE && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (finish_if) begin
                if_data_o <= mem_rdata_i;
            end
            if (finish_dm && !is_store) begin
                dm_rdata_o <= mem_rdata_i;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_if_wait_o <= '0;
            perf_dm_wait_o <= '0;
        end else begin
            if (if_elig && perf_if_wait_o != '1) begin
                perf_if_wait_o <= perf_if_wait_o + CNT_W'(1);
            end
            if (dm_elig && perf_dm_wait_o != '1) begin
                perf_dm_wait_o <= perf_dm_wait_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// cycle-accounting reference model. Perf checks are active when MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MEM_LAT  = 3;
    localparam int CNT_W    = 4;
    localparam int PERF_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;
    logic              dm_req_i = 1'b0;
    logic              dm_we_i = 1'b0;
    logic [ADDR_W-1:0] dm_addr_i = '0;
    logic [DATA_W-1:0] dm_wdata_i = '0;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              stall_o;
`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0]  perf_if_wait_o;
    logic [CNT_W-1:0]  perf_dm_wait_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_wait_o(perf_if_wait_o), .perf_dm_wait_o(perf_dm_wait_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: explicit entries, otherwise a fixed hash of the address.
    logic [DATA_W-1:0] mem_img [logic [ADDR_W-1:0]];
    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Fixed-latency memory: read data valid only MEM_LAT cycles after an issue, noise otherwise.
    int                resp_cycle = -1;
    logic [ADDR_W-1:0] resp_addr = '0;
    always @(negedge clk) begin
        if (mem_en_o === 1'b1) begin
            resp_cycle = cyc + MEM_LAT;
            resp_addr  = mem_addr_o;
        end
    end
    always @(posedge clk) begin
        #1;
        if (cyc == resp_cycle) mem_rdata_i = mem_rd(resp_addr);
        else mem_rdata_i = $urandom;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if_req_i = 1'($urandom); dm_req_i = 1'($urandom); dm_we_i = 1'($urandom);
            if_addr_i = $urandom; dm_addr_i = $urandom; dm_wdata_i = $urandom;
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if ({mem_en_o, mem_we_o, if_ack_o, dm_ack_o} !== 4'b0000 || mem_addr_o !== '0 ||
                    mem_wdata_o !== '0 || if_data_o !== '0 || dm_rdata_o !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs k=%0d got en=%b we=%b ifa=%b dma=%b addr=%h wd=%h ifd=%h dmd=%h, want all 0",
                             k, mem_en_o, mem_we_o, if_ack_o, dm_ack_o, mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o);
                end
                checks++;
                if (stall_o !== (if_req_i | dm_req_i)) begin
                    errors++;
                    $display("FAIL reset_stall k=%0d got %b want %b", k, stall_o, if_req_i | dm_req_i);
                end
`ifdef MEM_ARB_PERF_EN
                checks++;
                if (perf_if_wait_o !== '0 || perf_dm_wait_o !== '0) begin
                    errors++;
                    $display("FAIL reset_perf got if=%0d dm=%0d want 0", perf_if_wait_o, perf_dm_wait_o);
                end
`endif
            end
        end
        @(posedge clk); #1;
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; rst_i = 1'b1;
    endtask

    task automatic test_fetch();
        logic [3:0] got, exp;
        mem_img[32'h40] = 32'h8C020000;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 0) if_addr_i = 32'h40;
            else if_addr_i = $urandom;
            if_req_i = (k <= 5);
            @(negedge clk);
            got = {if_ack_o, dm_ack_o, mem_en_o, stall_o};
            exp = {k == 5, 1'b0, k == 1, k <= 4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fetch_ctrl k=%0d got ifa/dma/en/stall=%b want %b", k, got, exp);
            end
            if (k == 1) begin
                checks++;
                if (mem_addr_o !== 32'h40 || mem_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_issue got addr=%h we=%b want 00000040/0", mem_addr_o, mem_we_o);
                end
            end
            if (k == 5) begin
                checks++;
                if (if_data_o !== 32'h8C020000 || mem_addr_o !== 32'h40) begin
                    errors++;
                    $display("FAIL fetch_data got data=%h addr=%h want 8c020000/00000040", if_data_o, mem_addr_o);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] got, exp;
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                if_addr_i = 32'h44; dm_addr_i = 32'h100; dm_we_i = 1'b0;
            end
            dm_req_i = (k <= 5);
            if_req_i = (k <= 10);
            @(negedge clk);
            got = {if_ack_o, dm_ack_o, mem_en_o, stall_o};
            exp = {k == 10, k == 5, k == 1 || k == 6, k <= 9};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL arb_ctrl k=%0d got ifa/dma/en/stall=%b want %b", k, got, exp);
            end
            if (k == 1 || k == 6) begin
                checks++;
                if (mem_addr_o !== (k == 1 ? 32'h100 : 32'h44) || mem_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL arb_issue k=%0d got addr=%h we=%b", k, mem_addr_o, mem_we_o);
                end
            end
            if (k == 5) begin
                checks++;
                if (dm_rdata_o !== mem_rd(32'h100)) begin
                    errors++;
                    $display("FAIL arb_dm_data got %h want %h", dm_rdata_o, mem_rd(32'h100));
                end
            end
            if (k == 10) begin
                checks++;
                if (if_data_o !== mem_rd(32'h44)) begin
                    errors++;
                    $display("FAIL arb_if_data got %h want %h", if_data_o, mem_rd(32'h44));
                end
            end
`ifdef MEM_ARB_PERF_EN
            if (k == 11) begin
                checks++;
                if (perf_if_wait_o !== CNT_W'(10) || perf_dm_wait_o !== CNT_W'(5)) begin
                    errors++;
                    $display("FAIL arb_perf got if=%0d dm=%0d want 10/5", perf_if_wait_o, perf_dm_wait_o);
                end
            end
`endif
        end
    endtask

    task automatic test_store();
        logic [3:0]        got, exp;
        logic [DATA_W-1:0] prev;
        prev = mem_rd(32'h100);
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
            end else begin
                dm_wdata_i = $urandom; dm_addr_i = $urandom;
            end
            dm_req_i = (k <= 5);
            @(negedge clk);
            got = {if_ack_o, dm_ack_o, mem_en_o, stall_o};
            exp = {1'b0, k == 5, k == 1, k <= 4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL store_ctrl k=%0d got ifa/dma/en/stall=%b want %b", k, got, exp);
            end
            if (k == 1) begin
                checks++;
                if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_wdata_o !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL store_issue got we=%b addr=%h wd=%h want 1/00000200/deadbeef", mem_we_o, mem_addr_o, mem_wdata_o);
                end
            end
            if (k == 2) begin
                checks++;
                if (mem_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL store_we_drop got %b want 0", mem_we_o);
                end
            end
            if (k == 5) begin
                checks++;
                if (dm_rdata_o !== prev || mem_wdata_o !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL store_ack got rdata=%h wd=%h want %h/deadbeef", dm_rdata_o, mem_wdata_o, prev);
                end
            end
        end
        dm_we_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, exp;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 0) if_addr_i = 32'h80;
            if (k == 3) if_addr_i = 32'h84;
            rst_i = (k != 2);
            if_req_i = (k <= 8);
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h80) begin
                    errors++;
                    $display("FAIL rstmid_issue got en=%b addr=%h want 1/00000080", mem_en_o, mem_addr_o);
                end
            end
            if (k >= 3) begin
                got = {if_ack_o, dm_ack_o, mem_en_o, stall_o};
                exp = {k == 8, 1'b0, k == 4, k <= 7};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rstmid_ctrl k=%0d got ifa/dma/en/stall=%b want %b", k, got, exp);
                end
            end
            if (k == 3) begin
                checks++;
                if (mem_addr_o !== '0 || mem_wdata_o !== '0 || mem_we_o !== 1'b0 || if_data_o !== '0 || dm_rdata_o !== '0) begin
                    errors++;
                    $display("FAIL rstmid_clear got addr=%h wd=%h we=%b ifd=%h dmd=%h want 0",
                             mem_addr_o, mem_wdata_o, mem_we_o, if_data_o, dm_rdata_o);
                end
            end
            if (k == 8) begin
                checks++;
                if (if_data_o !== mem_rd(32'h84)) begin
                    errors++;
                    $display("FAIL rstmid_refetch got %h want %h", if_data_o, mem_rd(32'h84));
                end
            end
        end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf_saturate();
        int want;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k <= 6; k++) begin
                @(posedge clk); #1;
                if (k == 0) if_addr_i = 32'($urandom_range(255) * 4);
                if_req_i = (k <= 5);
                @(negedge clk);
                if (k == 5) begin
                    checks++;
                    if (if_ack_o !== 1'b1) begin
                        errors++;
                        $display("FAIL perf_fetch_ack n=%0d got %b want 1", n, if_ack_o);
                    end
                end
            end
            want = (5 * (n + 1) > PERF_MAX) ? PERF_MAX : 5 * (n + 1);
            checks++;
            if (perf_if_wait_o !== CNT_W'(want) || perf_dm_wait_o !== '0) begin
                errors++;
                $display("FAIL perf_sat n=%0d got if=%0d dm=%0d want %0d/0", n, perf_if_wait_o, perf_dm_wait_o, want);
            end
        end
    endtask
`endif

    task automatic test_random();
        int                free_at = 0;
        int                if_ack_at = -10;
        int                dm_ack_at = -10;
        int                issue_at = -10;
        logic              if_act = 1'b0;
        logic              dm_act = 1'b0;
        logic              dm_st = 1'b0;
        logic              iss_we = 1'b0;
        logic [ADDR_W-1:0] iss_addr = '0;
        logic [DATA_W-1:0] iss_wdata = '0;
        logic [DATA_W-1:0] if_ld = '0;
        logic [DATA_W-1:0] dm_ld = '0;
        logic [DATA_W-1:0] exp_if_data = '0;
        logic [DATA_W-1:0] exp_dm_data = '0;
        int                perf_if = 0;
        int                perf_dm = 0;
        logic              e_ifa, e_dma, e_en, e_stall;
        logic [4:0]        got, exp;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            // Requesters: drop after the ack cycle, may wander or drop while served, else maybe request.
            if (c - 1 == if_ack_at) if_req_i = 1'b0;
            else if (if_act) begin
                if_addr_i = $urandom;
                if ($urandom_range(15) == 0) if_req_i = 1'b0;
            end else if (!if_req_i && $urandom_range(2) == 0) begin
                if_req_i = 1'b1; if_addr_i = 32'($urandom_range(255) * 4);
            end
            if (c - 1 == dm_ack_at) dm_req_i = 1'b0;
            else if (dm_act) begin
                dm_addr_i = $urandom; dm_wdata_i = $urandom; dm_we_i = 1'($urandom);
                if ($urandom_range(15) == 0) dm_req_i = 1'b0;
            end else if (!dm_req_i && $urandom_range(2) == 0) begin
                dm_req_i = 1'b1; dm_we_i = 1'($urandom);
                dm_addr_i = 32'($urandom_range(255) * 4 + 32'h1000); dm_wdata_i = $urandom;
            end
            // Memory is a single resource: free again on the ack cycle; data port has priority.
            if (c >= free_at) begin
                if (dm_req_i && c != dm_ack_at) begin
                    dm_act = 1'b1; dm_ack_at = c + MEM_LAT + 2; issue_at = c + 1; free_at = dm_ack_at;
                    iss_addr = dm_addr_i; iss_we = dm_we_i; iss_wdata = dm_wdata_i;
                    dm_st = dm_we_i; dm_ld = mem_rd(dm_addr_i);
                end else if (if_req_i && c != if_ack_at) begin
                    if_act = 1'b1; if_ack_at = c + MEM_LAT + 2; issue_at = c + 1; free_at = if_ack_at;
                    iss_addr = if_addr_i; iss_we = 1'b0; if_ld = mem_rd(if_addr_i);
                end
            end
            @(negedge clk);
            e_ifa   = (c == if_ack_at);
            e_dma   = (c == dm_ack_at);
            e_en    = (c == issue_at);
            e_stall = (if_req_i && !e_ifa) || (dm_req_i && !e_dma);
            if (e_ifa) exp_if_data = if_ld;
            if (e_dma && !dm_st) exp_dm_data = dm_ld;
            if (if_req_i && !e_ifa && perf_if < PERF_MAX) perf_if++;
            if (dm_req_i && !e_dma && perf_dm < PERF_MAX) perf_dm++;
            got = {if_ack_o, dm_ack_o, mem_en_o, mem_we_o, stall_o};
            exp = {e_ifa, e_dma, e_en, e_en && iss_we, e_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rnd_ctrl c=%0d got ifa/dma/en/we/stall=%b want %b", c, got, exp);
            end
            if (e_en) begin
                checks++;
                if (mem_addr_o !== iss_addr || (iss_we && mem_wdata_o !== iss_wdata)) begin
                    errors++;
                    $display("FAIL rnd_issue c=%0d got addr=%h wd=%h want addr=%h wd=%h we=%b",
                             c, mem_addr_o, mem_wdata_o, iss_addr, iss_wdata, iss_we);
                end
            end
            checks++;
            if (if_data_o !== exp_if_data || dm_rdata_o !== exp_dm_data) begin
                errors++;
                $display("FAIL rnd_data c=%0d got ifd=%h dmd=%h want ifd=%h dmd=%h",
                         c, if_data_o, dm_rdata_o, exp_if_data, exp_dm_data);
            end
`ifdef MEM_ARB_PERF_EN
            checks++;
            if (perf_if_wait_o !== CNT_W'(perf_if) || perf_dm_wait_o !== CNT_W'(perf_dm)) begin
                errors++;
                $display("FAIL rnd_perf c=%0d got if=%0d dm=%0d want %0d/%0d",
                         c, perf_if_wait_o, perf_dm_wait_o, perf_if, perf_dm);
            end
`endif
            if (e_ifa) if_act = 1'b0;
            if (e_dma) dm_act = 1'b0;
        end
        @(posedge clk); #1;
        if_req_i = 1'b0; dm_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_store();
        test_reset_mid();
`ifdef MEM_ARB_PERF_EN
        test_perf_saturate();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
